// File: rtl/stack_retorno_pkg.sv
// stack_retorno_pkg: shared widths and op encoding
// for the return-address stack.
package stack_retorno_pkg;

    localparam int ADDR_W    = 10;
    localparam int RAS_DEPTH = 8;
    localparam int RAS_PTR_W = 3;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } ras_op_e;

endpackage

// File: rtl/stack_retorno_if.sv
// stack_retorno_if: call/return bundle between
// the PC path and the return-address stack.
interface stack_retorno_if
    import stack_retorno_pkg::*;
#(
    parameter int WIDTH = ADDR_W,
    parameter int PTR_W = RAS_PTR_W
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, d,
        input  q, count, empty, full,
        input  overflow, underflow
    );

    modport slave (
        input  push, pop, d,
        output q, count, empty, full,
        output overflow, underflow
    );
endinterface

// File: rtl/stack_retorno_mem.sv
// stack_mem: DEPTH x WIDTH array, one sync
// write port and one combinational read port.
module stack_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [PTR_W-1:0] ra,
    output logic [WIDTH-1:0] rd
);
    logic [WIDTH-1:0] mem [DEPTH];

    // write the addressed entry; contents never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];
endmodule

// File: rtl/stack_retorno.sv
// stack_retorno: return-address LIFO for nested
// calls; q shows top entry, 0 when empty.
module stack_retorno
    import stack_retorno_pkg::*;
#(
    parameter int WIDTH = ADDR_W,
    parameter int DEPTH = RAS_DEPTH,
    parameter int PTR_W = RAS_PTR_W
) (
    input  logic            clk,
    input  logic            reset,
    stack_retorno_if.slave  bus
);
    localparam logic [PTR_W:0] ONE =
        (PTR_W+1)'(1);
    localparam logic [PTR_W:0] FULL_CNT =
        (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] IDX_ONE =
        PTR_W'(1);

    logic [PTR_W:0]   count_r;
    logic             ovf_r;
    logic             udf_r;
    logic [PTR_W-1:0] top_idx;
    logic             is_empty;
    logic             is_full;
    ras_op_e          op;
    logic             ovf_set;
    logic             udf_set;
    logic             we;
    logic [PTR_W-1:0] wa;
    logic [WIDTH-1:0] rd;

    assign top_idx  = count_r[PTR_W-1:0] - IDX_ONE;
    assign is_empty = (count_r == '0);
    assign is_full  = (count_r == FULL_CNT);

    // classify this cycle's push/pop request
    always_comb begin
        op      = OP_HOLD;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        unique case ({bus.push, bus.pop})
            2'b10: begin
                if (is_full) ovf_set = 1'b1;
                else         op = OP_PUSH;
            end
            2'b01: begin
                if (is_empty) udf_set = 1'b1;
                else          op = OP_POP;
            end
            2'b11: begin
                op = is_empty ? OP_PUSH : OP_REPL;
            end
            default: op = OP_HOLD;
        endcase
    end

    // reset blocks the write so no stale entry lands
    assign we = !reset &&
                (op == OP_PUSH || op == OP_REPL);
    assign wa = (op == OP_REPL) ? top_idx
                                : count_r[PTR_W-1:0];

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk (clk),
        .we  (we),
        .wa  (wa),
        .wd  (bus.d),
        .ra  (top_idx),
        .rd  (rd)
    );

    // entry count and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            unique case (op)
                OP_PUSH: count_r <= count_r + ONE;
                OP_POP:  count_r <= count_r - ONE;
                default: count_r <= count_r;
            endcase
            if (ovf_set) ovf_r <= 1'b1;
            if (udf_set) udf_r <= 1'b1;
        end
    end

    assign bus.q         = is_empty ? '0 : rd;
    assign bus.count     = count_r;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_r;
    assign bus.underflow = udf_r;
endmodule

// File: tb/tb_stack_retorno.sv
// tb_stack_retorno: vector table plus scoreboard
// queue for the return-address stack.
module tb_stack_retorno;
    import stack_retorno_pkg::*;

    typedef struct {
        logic       rst;
        logic       push;
        logic       pop;
        logic [9:0] d;
        logic [9:0] q;
        logic [3:0] count;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       udf;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    vec_t vecs[$];
    vec_t sb[$];

    stack_retorno_if bus ();

    stack_retorno dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void add(
        input logic       rst,
        input logic       push,
        input logic       pop,
        input logic [9:0] d,
        input logic [9:0] q,
        input logic [3:0] count,
        input logic       ovf,
        input logic       udf
    );
        vec_t v;
        v.rst   = rst;
        v.push  = push;
        v.pop   = pop;
        v.d     = d;
        v.q     = q;
        v.count = count;
        v.empty = (count == 4'd0);
        v.full  = (count == 4'd8);
        v.ovf   = ovf;
        v.udf   = udf;
        vecs.push_back(v);
    endfunction

    task automatic chk(
        input string       name,
        input int          idx,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h exp=%0h",
                     name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        reset    = v.rst;
        bus.push = v.push;
        bus.pop  = v.pop;
        bus.d    = v.d;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty vec=%0d got=0 exp=1",
                     idx);
        end else begin
            e = sb.pop_front();
            chk("q", idx, 32'(bus.q), 32'(e.q));
            chk("count", idx, 32'(bus.count),
                32'(e.count));
            chk("empty", idx, 32'(bus.empty),
                32'(e.empty));
            chk("full", idx, 32'(bus.full),
                32'(e.full));
            chk("overflow", idx, 32'(bus.overflow),
                32'(e.ovf));
            chk("underflow", idx, 32'(bus.underflow),
                32'(e.udf));
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.d    = '0;

        // reset then idle
        add(1, 0, 0, 10'h000, 10'h000, 0, 0, 0);
        add(0, 0, 0, 10'h000, 10'h000, 0, 0, 0);

        // three pushes, three pops
        add(0, 1, 0, 10'h005, 10'h005, 1, 0, 0);
        add(0, 1, 0, 10'h012, 10'h012, 2, 0, 0);
        add(0, 1, 0, 10'h3FF, 10'h3FF, 3, 0, 0);
        add(0, 0, 1, 10'h000, 10'h012, 2, 0, 0);
        add(0, 0, 1, 10'h000, 10'h005, 1, 0, 0);
        add(0, 0, 1, 10'h000, 10'h000, 0, 0, 0);

        // fill, overflow, drain
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, 10'(10'h100 + i),
                10'(10'h100 + i), 4'(i + 1), 0, 0);
        add(0, 1, 0, 10'h2AA, 10'h107, 8, 1, 0);
        for (int k = 0; k < 8; k++)
            add(0, 0, 1, 10'h000,
                (k < 7) ? 10'(10'h106 - k) : 10'h000,
                4'(7 - k), 1, 0);
        add(1, 0, 0, 10'h000, 10'h000, 0, 0, 0);

        // underflow then push
        add(0, 0, 1, 10'h000, 10'h000, 0, 0, 1);
        add(0, 1, 0, 10'h001, 10'h001, 1, 0, 1);
        add(1, 0, 0, 10'h000, 10'h000, 0, 0, 0);

        // replace top, and push+pop on empty
        add(0, 1, 0, 10'h050, 10'h050, 1, 0, 0);
        add(0, 1, 0, 10'h060, 10'h060, 2, 0, 0);
        add(0, 1, 1, 10'h077, 10'h077, 2, 0, 0);
        add(0, 0, 1, 10'h000, 10'h050, 1, 0, 0);
        add(0, 0, 1, 10'h000, 10'h000, 0, 0, 0);
        add(0, 1, 1, 10'h011, 10'h011, 1, 0, 0);
        add(1, 0, 0, 10'h000, 10'h000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // hand sequence: replace while full,
        // then reset racing a push
        vecs.delete();
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, 10'(10'h200 + i),
                10'(10'h200 + i), 4'(i + 1), 0, 0);
        add(0, 1, 1, 10'h1EE, 10'h1EE, 8, 0, 0);
        add(0, 1, 0, 10'h2AA, 10'h1EE, 8, 1, 0);
        add(0, 0, 1, 10'h000, 10'h206, 7, 1, 0);
        add(0, 0, 1, 10'h000, 10'h205, 6, 1, 0);
        add(0, 0, 1, 10'h000, 10'h204, 5, 1, 0);
        add(0, 0, 1, 10'h000, 10'h203, 4, 1, 0);
        add(1, 1, 0, 10'h3AB, 10'h000, 0, 0, 0);
        add(0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
        add(0, 1, 0, 10'h3C3, 10'h3C3, 1, 0, 0);
        add(0, 1, 0, 10'h0F0, 10'h0F0, 2, 0, 0);
        add(0, 0, 1, 10'h000, 10'h3C3, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], 100 + i);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule

// File: doc/stack_retorno.md
Name: stack_retorno

Overview:
Return-address stack (LIFO) for the CPU's subroutine call/return path. It replaces the single-entry jal return register so calls can nest. It sits between the PC incrementer and the PC-source mux:
- on a call, the 10-bit PC+1 value from the adder is pushed;
- on a return, the top entry feeds the PC mux and is popped.

Parameters:
- WIDTH, 10: return-address width; matches PC width.
- DEPTH, 8: number of stack entries; must be a power of two, >= 2.
- PTR_W, 3: log2(DEPTH); width of the stack-pointer index.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  call: store d on top of stack this cycle.
- pop  input  1  return: remove top entry this cycle.
- d  input  WIDTH  return address to push (PC+1 from the adder).
- q  output  WIDTH  current top-of-stack entry; 0 when empty.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was rejected because the stack was full.
- underflow  output  1  sticky: a pop was rejected because the stack was empty.

Behaviour:
- One clock (clk); reset is synchronous and active-high. State changes only on the rising edge of clk, and reset is sampled there.
- Reset effects:
  - count <= 0 and both sticky flags <= 0.
  - Storage array is not cleared.
  - After reset: q = 0, empty = 1, full = 0.
  - Reset wins over push/pop in the same cycle.
  - Reset mid-sequence discards all entries.
- Read path:
  - q is combinational from the registered storage and count: q = mem[count-1] when count != 0, else 0.
  - No read latency; the effect of a push/pop is visible on q the cycle after the edge.
- Operations per edge, with reset low:
  - push only, not full: mem[count] <= d; count <= count+1.
  - push only, full: no write, count unchanged; overflow <= 1.
  - pop only, not empty: count <= count-1; entry contents untouched.
  - pop only, empty: count unchanged; underflow <= 1.
  - push and pop, not empty: replace top, i.e. mem[count-1] <= d, count unchanged, no flag.
  - push and pop, empty: behaves as push only; underflow not set.
  - neither: hold.
- Sticky flags clear only on reset.
- empty and full are combinational from count. full and push-and-pop together is legal (replace top).
- No wrap-around: the pointer never passes 0 or DEPTH. Index arithmetic is PTR_W+1 bits wide, unsigned.
- Illegal DEPTH (not a power of two, or DEPTH/PTR_W mismatch) is a configuration error; no runtime checking.

Decomposition:
- Shared include file cpu_defs.vh holds:
  - ADDR_W = 10 (PC width, also used by the PC register and adder);
  - RAS_DEPTH = 8, RAS_PTR_W = 3.
- stack_retorno instantiates these as parameter defaults.
- One natural sub-module: stack_mem. It is a DEPTH x WIDTH array with one synchronous write port (we, wa, wd) and one combinational read port (ra, rd), with the same structure as the register file but without the zero-register rule.
- The top level holds the count register, sticky flags, operation decode and q masking.

Test Plan:
1. Reset then idle -> q=0, count=0, empty=1, full=0, overflow=0, underflow=0.
2. Push 10'h005, 10'h012, 10'h3FF on consecutive cycles -> q reads 005, 012, 3FF after each edge, count=3. Then pop three times -> q=012, 005, 0; empty=1 after the last pop.
3. Push 8 distinct values 10'h100..10'h107 -> full=1, q=107. 9th push of 10'h2AA -> overflow=1, count=8, q=107. Pop 8 times -> values 107..100 in order.
4. From empty, pop -> underflow=1, count=0, q=0. Then push 10'h001 -> q=001, count=1, underflow remains 1.
5. Stack holding 10'h050, 10'h060: push+pop with d=10'h077 -> count=2, q=077. Pop -> q=050. Simultaneous push+pop on empty with d=10'h011 -> count=1, q=011, underflow=0.
6. With 4 entries and overflow=1, assert reset together with push -> next cycle count=0, q=0, overflow=0, no entry written.
